serial_full_adder_ctrl: RTL

//  Bit-serial adder stage that drives a single one-bit full-adder cell, one operand bit per cycle.

---
 rtl/serial_full_adder_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/serial_full_adder_ctrl.sv
// Bit-serial adder: streams two WIDTH-bit operands LSB-first through a one-bit
// full-adder cell, recirculating the carry, and returns the sum over valid/ready.

module full_adder_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_carry_in,
  output logic o_res,
  output logic o_carry_out
);
  assign o_res       = i_a ^ i_b ^ i_carry_in;
  assign o_carry_out = (i_a & i_b) | (i_carry_in & (i_a ^ i_b));
endmodule

module serial_full_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry_in,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry_out,
  output logic             o_busy
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_sa;
  logic [WIDTH-1:0]   r_sb;
  logic               r_creg;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry_out;
  logic               w_res;
  logic               w_cout;
  logic               w_last;
  logic               w_run;
  logic [WIDTH-1:0]   w_final;

  full_adder_cell u_cell (
    .i_a         (r_sa[0]),
    .i_b         (r_sb[0]),
    .i_carry_in  (r_creg),
    .o_res       (w_res),
    .o_carry_out (w_cout)
  );

  assign w_run  = (r_state == S_RUN);
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // Result bits collected so far live in r_acc; the current cell output
  // completes the MSB, so only WIDTH-1 bits of history are stored.
  generate
    if (WIDTH == 1) begin : g_acc_single
      assign w_final = w_res;
    end else begin : g_acc_multi
      logic [WIDTH-2:0] r_acc;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_acc <= '0;
        end else if (w_run) begin
          r_acc <= w_final[WIDTH-1:1];
        end
      end

      assign w_final = {w_res, r_acc};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_in_valid)  w_state_next = S_RUN;
      S_RUN:   if (w_last)      w_state_next = S_DONE;
      S_DONE:  if (i_out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_in_ready  = (r_state == S_IDLE);
    o_busy      = (r_state == S_RUN);
    o_out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa        <= '0;
      r_sb        <= '0;
      r_creg      <= 1'b0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_carry_out <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_sa   <= i_a;
            r_sb   <= i_b;
            r_creg <= i_carry_in;
            r_cnt  <= '0;
          end
        end
        S_RUN: begin
          r_sa   <= r_sa >> 1;
          r_sb   <= r_sb >> 1;
          r_creg <= w_cout;
          r_cnt  <= r_cnt + CNT_W'(1);
          // Result registers change only here, so they hold through the next RUN.
          if (w_last) begin
            r_sum       <= w_final;
            r_carry_out <= w_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_sum       = r_sum;
  assign o_carry_out = r_carry_out;

endmodule
